vadd_stream_source: RTL and testbench

//   Multi-channel AXI4-Stream transmitter feeding the vector-adder kernel's s_ side.
//   On a start pulse, sends len beats of a deterministic arithmetic pattern on

---
 rtl/vadd_stream_source_if.sv | 25 ++
 rtl/vadd_stream_source.sv | 110 +++++++++++
 tb/tb_vadd_stream_source.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vadd_stream_source_if.sv
// AXI4-Stream bundle for the vector-adder stimulus source. There is one
// valid/ready/last lane per channel, and the data lanes are packed side by side.
interface vadd_stream_source_if #(
    parameter int unsigned C_NUM_CHANNELS = 2,
    parameter int unsigned C_DATA_WIDTH   = 32
);
    logic [C_NUM_CHANNELS-1:0]              tvalid;
    logic [C_NUM_CHANNELS-1:0]              tready;
    logic [C_NUM_CHANNELS*C_DATA_WIDTH-1:0] tdata;
    logic [C_NUM_CHANNELS-1:0]              tlast;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/vadd_stream_source.sv
// Multi-channel stream transmitter. A start pulse makes every channel send len beats
// of seed + k*C_NUM_CHANNELS + c, and done pulses once all channels have finished.
module vadd_stream_source #(
    parameter int unsigned C_NUM_CHANNELS = 2,
    parameter int unsigned C_DATA_WIDTH   = 32,
    parameter int unsigned C_LEN_WIDTH    = 16
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    start,
    input  logic [C_LEN_WIDTH-1:0]  len,
    input  logic [C_DATA_WIDTH-1:0] seed,
    output logic                    busy,
    output logic                    done,
    vadd_stream_source_if.master    m
);
    localparam int unsigned N = C_NUM_CHANNELS;
    localparam int unsigned W = C_DATA_WIDTH;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                       state_q, state_d;
    logic [C_LEN_WIDTH-1:0]       len_q, len_d;
    logic [N-1:0][C_LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [N-1:0]                 tvalid_q, tvalid_d;
    logic [N-1:0]                 tlast_q, tlast_d;
    logic [N*W-1:0]               tdata_q, tdata_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic [C_LEN_WIDTH-1:0]       last_idx;

    assign last_idx = len_q - C_LEN_WIDTH'(1);

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tdata_d  = tdata_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d = len;
                    cnt_d = '0;
                    if (len == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d  = StRun;
                        tvalid_d = '1;
                        tlast_d  = {N{len == C_LEN_WIDTH'(1)}};
                        for (int unsigned c = 0; c < N; c++) begin
                            tdata_d[c*W +: W] = seed + W'(c);
                        end
                    end
                end
            end
            StRun: begin
                for (int unsigned c = 0; c < N; c++) begin
                    if (tvalid_q[c] && m.tready[c]) begin
                        if (tlast_q[c]) begin
                            tvalid_d[c] = 1'b0;
                            tlast_d[c]  = 1'b0;
                        end else begin
                            // Stepping by N keeps the channels interleaved: beat k is seed+k*N+c.
                            cnt_d[c]          = cnt_q[c] + C_LEN_WIDTH'(1);
                            tdata_d[c*W +: W] = tdata_q[c*W +: W] + W'(N);
                            tlast_d[c]        = (cnt_q[c] + C_LEN_WIDTH'(1)) == last_idx;
                        end
                    end
                end
                if (tvalid_d == '0) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= StIdle;
            len_q    <= '0;
            cnt_q    <= '0;
            tvalid_q <= '0;
            tlast_q  <= '0;
            tdata_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tdata_q  <= tdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign m.tvalid = tvalid_q;
    assign m.tlast  = tlast_q;
    assign m.tdata  = tdata_q;
endmodule

// File: tb/tb_vadd_stream_source.sv
// Randomised bench for vadd_stream_source: a per-channel beat-index model is checked
// every cycle, alongside literal expectations for the directed scenarios.
module tb_vadd_stream_source;
    localparam int N  = 2;
    localparam int W  = 32;
    localparam int LW = 16;

    logic          aclk    = 1'b0;
    logic          aresetn = 1'b0;
    logic          start   = 1'b0;
    logic [LW-1:0] len     = '0;
    logic [W-1:0]  seed    = '0;
    logic          busy;
    logic          done;

    vadd_stream_source_if #(.C_NUM_CHANNELS(N), .C_DATA_WIDTH(W)) sif ();

    vadd_stream_source #(
        .C_NUM_CHANNELS(N),
        .C_DATA_WIDTH  (W),
        .C_LEN_WIDTH   (LW)
    ) dut (
        .aclk   (aclk),
        .aresetn(aresetn),
        .start  (start),
        .len    (len),
        .seed   (seed),
        .busy   (busy),
        .done   (done),
        .m      (sif)
    );

    always #5 aclk = ~aclk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int e_cyc    = 0;

    // Model: transfer in progress, done pulse, next beat index and finished flag per channel.
    bit           m_active = 0;
    bit           m_done   = 0;
    int           m_k[N];
    bit           m_fin[N];
    logic [W-1:0] m_seed = '0;
    int           m_len  = 0;

    // Observations made on the DUT outputs.
    logic [W-1:0] log0[$];
    logic [W-1:0] log1[$];
    int           busy_cycles = 0;
    int           done_cnt    = 0;
    int           done_cyc    = 0;
    int           valid_seen  = 0;
    int           fin_cyc[N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] beat(input int ch, input int idx);
        if (ch == 0) return (idx < log0.size()) ? log0[idx] : 'x;
        return (idx < log1.size()) ? log1[idx] : 'x;
    endfunction

    always @(posedge aclk) cyc <= cyc + 1;

    always @(posedge aclk or negedge aresetn) begin : model
        bit nf[N];
        bit all_fin;
        if (!aresetn) begin
            m_active <= 0;
            m_done   <= 0;
            for (int i = 0; i < N; i++) begin
                m_k[i]   <= 0;
                m_fin[i] <= 0;
            end
        end else if (m_done) begin
            m_done <= 0;
        end else if (!m_active) begin
            if (start) begin
                m_seed <= seed;
                m_len  <= int'(len);
                for (int i = 0; i < N; i++) begin
                    m_k[i]   <= 0;
                    m_fin[i] <= 0;
                end
                if (len == 0) m_done <= 1;
                else m_active <= 1;
            end
        end else begin
            all_fin = 1;
            for (int i = 0; i < N; i++) begin
                nf[i] = m_fin[i];
                if (!m_fin[i] && sif.tready[i]) begin
                    if (m_k[i] == m_len - 1) nf[i] = 1;
                    else m_k[i] <= m_k[i] + 1;
                end
                all_fin  = all_fin & nf[i];
                m_fin[i] <= nf[i];
            end
            if (all_fin) begin
                m_active <= 0;
                m_done   <= 1;
            end
        end
    end

    always @(negedge aclk) begin : compare
        logic [N-1:0] ev;
        logic [N-1:0] el;
        logic [W-1:0] ed;
        for (int i = 0; i < N; i++) begin
            ev[i] = m_active && !m_fin[i];
            el[i] = ev[i] && (m_k[i] == m_len - 1);
        end
        chk("busy", busy, m_active || m_done);
        chk("done", done, m_done);
        chk("tvalid", sif.tvalid, ev);
        chk("tlast", sif.tlast, el);
        for (int i = 0; i < N; i++) begin
            if (ev[i]) begin
                ed = m_seed + W'(m_k[i] * N + i);
                chk("tdata", sif.tdata[i*W +: W], ed);
            end
        end
        if (busy) busy_cycles++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (|sif.tvalid) valid_seen++;
        for (int i = 0; i < N; i++) begin
            if (sif.tvalid[i] && sif.tready[i]) begin
                if (i == 0) log0.push_back(sif.tdata[i*W +: W]);
                else log1.push_back(sif.tdata[i*W +: W]);
                if (sif.tlast[i]) fin_cyc[i] = cyc;
            end
        end
    end

    task automatic clr();
        log0.delete();
        log1.delete();
        busy_cycles = 0;
        done_cnt    = 0;
        valid_seen  = 0;
        for (int i = 0; i < N; i++) fin_cyc[i] = -1;
    endtask

    task automatic do_start(input logic [W-1:0] s, input int l);
        start = 1'b1;
        seed  = s;
        len   = LW'(l);
        e_cyc = cyc;
        @(posedge aclk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge aclk);
            #1;
            n++;
            if (rnd) begin
                sif.tready = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) begin
                    start = 1'b1;
                    seed  = $urandom;
                    len   = LW'($urandom_range(0, 5));
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        if (done_cnt == 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
        end
    endtask

    initial begin
        int l;
        sif.tready = 2'b11;
        clr();
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tvalid", sif.tvalid, 0);
        chk("rst_tlast", sif.tlast, 0);
        chk("rst_tdata", sif.tdata, 0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Basic transfer with continuous ready.
        clr();
        do_start(32'h10, 4);
        wait_done(50, 0);
        chk("t1_n0", log0.size(), 4);
        chk("t1_ch0_b0", beat(0, 0), 32'h10);
        chk("t1_ch0_b3", beat(0, 3), 32'h16);
        chk("t1_ch1_b0", beat(1, 0), 32'h11);
        chk("t1_ch1_b3", beat(1, 3), 32'h17);
        chk("t1_busy_cycles", busy_cycles, 5);
        chk("t1_done_lat", done_cyc, fin_cyc[0] + 1);
        chk("t1_done_cnt", done_cnt, 1);

        // Channel 1 stalls while channel 0 runs free.
        clr();
        sif.tready = 2'b01;
        do_start(32'h100, 3);
        repeat (4) begin
            @(posedge aclk);
            #1;
        end
        sif.tready = 2'b11;
        wait_done(50, 0);
        chk("t2_ch0_b2", beat(0, 2), 32'h104);
        chk("t2_ch1_b0", beat(1, 0), 32'h101);
        chk("t2_ch1_b2", beat(1, 2), 32'h105);
        chk("t2_order", fin_cyc[0] < fin_cyc[1], 1);
        chk("t2_done_lat", done_cyc, fin_cyc[1] + 1);

        // Data wraps modulo 2^32.
        clr();
        do_start(32'hFFFF_FFFE, 2);
        wait_done(50, 0);
        chk("t3_ch0_b0", beat(0, 0), 32'hFFFF_FFFE);
        chk("t3_ch0_b1", beat(0, 1), 32'h0000_0000);
        chk("t3_ch1_b0", beat(1, 0), 32'hFFFF_FFFF);
        chk("t3_ch1_b1", beat(1, 1), 32'h0000_0001);

        // A zero-length transfer goes straight to done.
        clr();
        do_start(32'h55, 0);
        wait_done(20, 0);
        chk("t4_valid_seen", valid_seen, 0);
        chk("t4_busy_cycles", busy_cycles, 1);
        chk("t4_done_lat", done_cyc, e_cyc + 1);

        // A start while busy is ignored.
        clr();
        do_start(32'h200, 6);
        repeat (2) begin
            @(posedge aclk);
            #1;
        end
        do_start(32'h999, 2);
        wait_done(50, 0);
        chk("t5_n0", log0.size(), 6);
        chk("t5_ch0_b5", beat(0, 5), 32'h20A);
        chk("t5_ch1_b0", beat(1, 0), 32'h201);
        chk("t5_done_cnt", done_cnt, 1);

        // Reset in the middle of a transfer aborts it without a done pulse.
        clr();
        do_start(32'h300, 8);
        @(posedge aclk);
        @(posedge aclk);
        #3;
        chk("t6_ch0_b2", sif.tdata[W-1:0], 32'h304);
        aresetn = 1'b0;
        #1;
        chk("t6_rst_tvalid", sif.tvalid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_tlast", sif.tlast, 0);
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        chk("t6_no_done", done_cnt, 0);
        clr();
        do_start(32'h400, 3);
        wait_done(50, 0);
        chk("t6_new_b0", beat(0, 0), 32'h400);
        chk("t6_new_ch1_b0", beat(1, 0), 32'h401);
        chk("t6_new_b2", beat(0, 2), 32'h404);

        // Random seeds and lengths, with random backpressure and stray start pulses.
        for (int t = 0; t < 30; t++) begin
            clr();
            l = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
            sif.tready = 2'($urandom_range(0, 3));
            do_start($urandom, l);
            wait_done(400, 1);
            chk("rnd_n0", log0.size(), l);
            chk("rnd_n1", log1.size(), l);
            chk("rnd_done_cnt", done_cnt, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000 time units");
        $fatal(1, "watchdog expired");
    end
endmodule
